// File: rtl/periph_rr_arbiter.sv
// periph_rr_arbiter
// Shares one valid/ready peripheral port among NUM_MASTERS requesters.
// Arbitration is round-robin with one transaction in flight at a time.
// Slave-side outputs are registered, and a watchdog completes a hung
// transaction with an error response.
// Each transaction walks IDLE -> BUSY -> DONE -> IDLE. DONE does not sample
// requests, which gives the master that was just served one cycle to drop
// m_valid before the next arbitration.

module periph_rr_arbiter #(
    parameter int          NUM_MASTERS    = 2,             // legal 2..4
    parameter int          TIMEOUT_CYCLES = 256,           // 0 disables the watchdog
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF  // read data on timeout
) (
    input  logic                      clk,
    input  logic                      reset,
    // requester side, master i packed at [32i+31:32i] / [4i+3:4i]
    input  logic [NUM_MASTERS-1:0]    m_valid,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [31:0]               m_rdata,
    // peripheral side
    output logic                      s_valid,
    input  logic                      s_ready,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_wstrb,
    input  logic [31:0]               s_rdata,
    // debug
    output logic [1:0]                grant_id
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int               CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST   = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    // With the last-served pointer at the top index, master 0 wins first after reset.
    localparam logic [1:0]       LAST_INIT = 2'(NUM_MASTERS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       last_q;

    // Arbitration result
    logic             pick_vld;
    logic [1:0]       pick_idx;
    logic [31:0]      pick_addr;
    logic [31:0]      pick_wdata;
    logic [3:0]       pick_wstrb;

    // Completion decode
    logic             in_idle;
    logic             in_busy;
    logic             start;
    logic             done_ok;
    logic             done_to;
    logic             done_any;
    logic [NUM_MASTERS-1:0] grant_oh;

    // Round-robin pick: scan last+1, last+2, ... and keep the first requester found.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        pick_vld   = 1'b0;
        pick_idx   = '0;
        pick_addr  = '0;
        pick_wdata = '0;
        pick_wstrb = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!pick_vld && m_valid[i] &&
                    (((int'(last_q) + k) % NUM_MASTERS) == i)) begin
                    pick_vld   = 1'b1;
                    pick_idx   = 2'(i);
                    pick_addr  = m_addr[32*i +: 32];
                    pick_wdata = m_wdata[32*i +: 32];
                    pick_wstrb = m_wstrb[4*i +: 4];
                end
            end
        end
    end

    assign in_idle  = (state_q == ST_IDLE);
    assign in_busy  = (state_q == ST_BUSY);
    assign start    = in_idle && pick_vld;
    // s_ready takes priority over a timeout that would fire in the same cycle.
    assign done_ok  = in_busy && s_ready;
    assign done_to  = in_busy && !s_ready && TO_EN && (cnt_q == TO_LAST);
    assign done_any = done_ok || done_to;

    // One-hot decode of the granted master for the completion pulses.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_oh[i] = (grant_id == 2'(i));
        end
    end

    // Next-state logic: DONE always returns to IDLE and never arbitrates.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_vld) state_d = ST_BUSY;
            ST_BUSY: if (done_any) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers: FSM state, watchdog counter, grant and last-served pointer.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is updated with non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= LAST_INIT;
            grant_id <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                grant_id <= pick_idx;
                cnt_q    <= '0;
            end else if (in_busy) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (done_any) begin
                last_q <= grant_id;
            end
        end
    end

    // Peripheral request registers: loaded on grant and held until completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
        end else if (start) begin
            s_valid <= 1'b1;
            s_addr  <= pick_addr;
            s_wdata <= pick_wdata;
            s_wstrb <= pick_wstrb;
        end else if (done_any) begin
            s_valid <= 1'b0;
        end
    end

    // Master response registers: single-cycle ready/err pulses; rdata holds until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_ready <= '0;
            m_err   <= '0;
            m_rdata <= '0;
        end else begin
            m_ready <= '0;
            m_err   <= '0;
            if (done_ok) begin
                m_ready <= grant_oh;
                m_rdata <= s_rdata;
            end else if (done_to) begin
                m_ready <= grant_oh;
                m_err   <= grant_oh;
                m_rdata <= ERR_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// tb_periph_rr_arbiter
// Self-checking bench for periph_rr_arbiter (2 masters, 8-cycle watchdog).
// The stimulus pushes the expected slave requests and master responses onto
// queues. A negedge monitor pops them and compares them with what the DUT
// presents. A small peripheral model answers after a programmable number of
// BUSY cycles.

module tb_periph_rr_arbiter;

    localparam int NM = 2;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM-1:0]     m_valid;
    logic [32*NM-1:0]  m_addr;
    logic [32*NM-1:0]  m_wdata;
    logic [4*NM-1:0]   m_wstrb;
    logic [NM-1:0]     m_ready;
    logic [NM-1:0]     m_err;
    logic [31:0]       m_rdata;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_rdata;
    logic [1:0]        grant_id;

    periph_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .m_rdata  (m_rdata),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .grant_id (grant_id)
    );

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int checks   = 0;
    int failures = 0;
    int s_txn    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_txn(input int m, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] rd, input logic e);
        req_q.push_back('{m: m, addr: a, wdata: d, wstrb: s});
        rsp_q.push_back('{m: m, rdata: rd, err: e});
    endtask

    task automatic set_master(input int i, input logic v, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        m_valid[i]          = v;
        m_addr[32*i +: 32]  = a;
        m_wdata[32*i +: 32] = d;
        m_wstrb[4*i +: 4]   = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an m_ready pulse; report which master got it and
    // how many cycles s_valid was seen high before it.
    task automatic wait_rsp(input int budget, output int busy, output int who);
        bit got = 1'b0;
        busy = 0;
        who  = -1;
        for (int c = 0; c < budget && !got; c++) begin
            tick();
            if (|m_ready) begin
                got = 1'b1;
                who = m_ready[1] ? 1 : 0;
            end else if (s_valid) begin
                busy++;
            end
        end
        check("rsp_seen", got, 1);
    endtask

    // ------------------------------------------------------------------
    // Peripheral model: asserts s_ready on BUSY cycle resp_at (0 = never)
    // ------------------------------------------------------------------
    int          resp_at   = 0;
    logic [31:0] resp_data = '0;
    int          busy_cnt  = 0;

    initial begin
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            tick();
            if (s_valid) busy_cnt++;
            else         busy_cnt = 0;
            s_ready = (resp_at != 0) && (busy_cnt == resp_at);
            s_rdata = resp_data;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares slave requests and master responses with the queues
    // ------------------------------------------------------------------
    initial begin
        logic        prev_sv;
        logic [31:0] hold_addr;
        logic [31:0] hold_wdata;
        logic [3:0]  hold_wstrb;
        req_t        r;
        rsp_t        p;
        logic [31:0] ev;
        prev_sv    = 1'b0;
        hold_addr  = '0;
        hold_wdata = '0;
        hold_wstrb = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_sv = 1'b0;
            end else begin
                if (s_valid && !prev_sv) begin
                    s_txn++;
                    check("req_pending", 32'(req_q.size() != 0), 1);
                    if (req_q.size() != 0) begin
                        r = req_q.pop_front();
                        check("grant_id", 32'(grant_id), r.m);
                        check("s_addr", s_addr, r.addr);
                        check("s_wdata", s_wdata, r.wdata);
                        check("s_wstrb", 32'(s_wstrb), 32'(r.wstrb));
                    end
                    hold_addr  = s_addr;
                    hold_wdata = s_wdata;
                    hold_wstrb = s_wstrb;
                end else if (s_valid) begin
                    check("s_hold", 32'(s_addr == hold_addr && s_wdata == hold_wdata &&
                                        s_wstrb == hold_wstrb), 1);
                end
                prev_sv = s_valid;

                if (|m_ready) begin
                    check("rsp_pending", 32'(rsp_q.size() != 0), 1);
                    if (rsp_q.size() != 0) begin
                        p  = rsp_q.pop_front();
                        ev = 32'(1) << p.m;
                        check("m_ready", 32'(m_ready), ev);
                        check("m_err", 32'(m_err), p.err ? ev : 32'(0));
                        check("m_rdata", m_rdata, p.rdata);
                    end
                end else if (|m_err) begin
                    check("m_err_no_ready", 32'(m_err), 0);
                end
            end
        end
    end

    // Absolute guard so the run always ends even if the DUT wedges.
    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not complete");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int busy;
        int who;
        int t0;
        int cnt0;
        int cnt1;

        reset   = 1'b1;
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        repeat (3) tick();

        // Reset values
        check("rst_s_valid", s_valid, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_s_wdata", s_wdata, 0);
        check("rst_s_wstrb", 32'(s_wstrb), 0);
        check("rst_m_ready", 32'(m_ready), 0);
        check("rst_m_err", 32'(m_err), 0);
        check("rst_m_rdata", m_rdata, 0);
        check("rst_grant_id", 32'(grant_id), 0);
        reset = 1'b0;
        tick();

        // Contention: both hold, immediate s_ready, grants 0,1,0,1
        resp_at   = 1;
        resp_data = 32'h0BAD_F00D;
        for (int n = 0; n < 4; n++) begin
            if (n % 2 == 0) expect_txn(0, 32'h10, 32'hAAAA_0000, 4'hF, 32'h0BAD_F00D, 1'b0);
            else            expect_txn(1, 32'h20, 32'h5555_0000, 4'h3, 32'h0BAD_F00D, 1'b0);
        end
        set_master(0, 1'b1, 32'h10, 32'hAAAA_0000, 4'hF);
        set_master(1, 1'b1, 32'h20, 32'h5555_0000, 4'h3);
        cnt0 = 0;
        cnt1 = 0;
        for (int n = 0; n < 4; n++) begin
            wait_rsp(20, busy, who);
            check("cont_who", who, n % 2);
            check("cont_busy", busy, 1);
            if (who == 0) begin
                cnt0++;
                if (cnt0 == 2) m_valid[0] = 1'b0;
            end
            if (who == 1) begin
                cnt1++;
                if (cnt1 == 2) m_valid[1] = 1'b0;
            end
        end
        m_valid = '0;
        repeat (3) tick();

        // Single read: s_ready three cycles after s_valid
        resp_at   = 4;
        resp_data = 32'h1234_5678;
        expect_txn(0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        set_master(0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
        tick();
        check("rd_s_valid_latency", s_valid, 1);
        wait_rsp(20, busy, who);
        check("rd_who", who, 0);
        check("rd_busy_rest", busy, 3);
        m_valid[0] = 1'b0;
        repeat (3) tick();
        check("rd_rdata_hold", m_rdata, 32'h1234_5678);

        // Timeout: master 1, peripheral never answers
        resp_at   = 0;
        resp_data = 32'h0;
        expect_txn(1, 32'h30, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
        set_master(1, 1'b1, 32'h30, 32'h0, 4'h0);
        wait_rsp(30, busy, who);
        check("to_who", who, 1);
        check("to_busy", busy, TO);
        check("to_s_valid", s_valid, 0);
        m_valid[1] = 1'b0;
        repeat (2) tick();

        // Next request after the timeout is served normally
        resp_at   = 2;
        resp_data = 32'hCAFE_0001;
        expect_txn(0, 32'h34, 32'h1111_2222, 4'hF, 32'hCAFE_0001, 1'b0);
        set_master(0, 1'b1, 32'h34, 32'h1111_2222, 4'hF);
        wait_rsp(20, busy, who);
        check("post_to_who", who, 0);
        check("post_to_busy", busy, 2);
        m_valid[0] = 1'b0;
        repeat (2) tick();

        // Tie: s_ready on BUSY cycle 8 wins over the watchdog
        resp_at   = TO;
        resp_data = 32'h7777_8888;
        expect_txn(1, 32'h40, 32'h0, 4'h0, 32'h7777_8888, 1'b0);
        set_master(1, 1'b1, 32'h40, 32'h0, 4'h0);
        wait_rsp(30, busy, who);
        check("tie_who", who, 1);
        check("tie_busy", busy, TO);
        check("tie_err", 32'(m_err), 0);
        m_valid[1] = 1'b0;
        repeat (2) tick();

        // Reset mid-transaction
        resp_at = 0;
        req_q.push_back('{m: 0, addr: 32'h50, wdata: 32'h0, wstrb: 4'h0});
        set_master(0, 1'b1, 32'h50, 32'h0, 4'h0);
        repeat (3) tick();
        check("mid_s_valid", s_valid, 1);
        reset   = 1'b1;
        m_valid = '0;
        tick();
        check("mid_rst_s_valid", s_valid, 0);
        check("mid_rst_s_addr", s_addr, 0);
        check("mid_rst_s_wdata", s_wdata, 0);
        check("mid_rst_s_wstrb", 32'(s_wstrb), 0);
        check("mid_rst_m_ready", 32'(m_ready), 0);
        check("mid_rst_m_err", 32'(m_err), 0);
        check("mid_rst_m_rdata", m_rdata, 0);
        check("mid_rst_grant_id", 32'(grant_id), 0);
        reset     = 1'b0;
        resp_at   = 1;
        resp_data = 32'h6060_6060;
        expect_txn(1, 32'h60, 32'h0, 4'h0, 32'h6060_6060, 1'b0);
        set_master(1, 1'b1, 32'h60, 32'h0, 4'h0);
        tick();
        check("post_rst_grant", 32'(grant_id), 1);
        // Master 0 raises its request while master 1 is in flight.
        expect_txn(0, 32'h70, 32'h0, 4'h0, 32'h6060_6060, 1'b0);
        set_master(0, 1'b1, 32'h70, 32'h0, 4'h0);
        wait_rsp(20, busy, who);
        check("post_rst_who1", who, 1);
        m_valid[1] = 1'b0;
        wait_rsp(20, busy, who);
        check("post_rst_who0", who, 0);
        m_valid[0] = 1'b0;
        repeat (3) tick();

        // No duplicate: master 0 keeps m_valid through the DONE cycle only
        resp_at   = 1;
        resp_data = 32'h0000_0ABC;
        expect_txn(0, 32'h80, 32'h9999_0000, 4'h1, 32'h0000_0ABC, 1'b0);
        t0 = s_txn;
        set_master(0, 1'b1, 32'h80, 32'h9999_0000, 4'h1);
        wait_rsp(20, busy, who);
        check("nodup_who", who, 0);
        tick();
        m_valid[0] = 1'b0;
        repeat (6) tick();
        check("nodup_txn", s_txn - t0, 1);

        // Every expected transaction was consumed
        check("req_q_left", req_q.size(), 0);
        check("rsp_q_left", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
